// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with runtime bit period, feeding a small show-ahead FIFO.
// Framing errors and overflow are reported as sticky flags.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int LVLW  = $clog2(DEPTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_rx,
    input  logic [15:0]     i_baud,
    input  logic            i_read,
    input  logic            i_clr_err,
    output logic [7:0]      o_D,
    output logic            o_ready,
    output logic [LVLW-1:0] o_level,
    output logic            o_busy,
    output logic            o_ferr,
    output logic            o_ovf
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

    state_t          state_q, state_d;
    logic            rx_m_q, rx_s_q, rx_p_q;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     per_q, per_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      sh_q, sh_d;
    logic [7:0]      mem_q [DEPTH];
    logic [LVLW-1:0] wr_q, rd_q;
    logic            ferr_q, ovf_q;

    logic [15:0]     baud_c;
    logic [LVLW-1:0] level;
    logic            cnt_zero, full, pop, accept;
    logic            push, set_ovf, set_ferr;

    assign baud_c   = (i_baud < 16'd4) ? 16'd4 : i_baud;
    assign cnt_zero = (cnt_q == 16'd0);
    assign level    = wr_q - rd_q;
    assign full     = (level == LVLW'(DEPTH));
    assign pop      = i_read && (level != '0);
    // A pop in the same cycle frees the slot the push is about to use.
    assign accept   = !full || pop;

    // State register and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_p_q  <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            per_q   <= 16'd4;
            idx_q   <= '0;
            sh_q    <= '0;
        end else begin
            rx_m_q  <= i_rx;
            rx_s_q  <= rx_m_q;
            rx_p_q  <= rx_s_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        case (state_q)
            S_IDLE: begin
                if (rx_p_q && !rx_s_q) begin
                    per_d   = baud_c;
                    cnt_d   = (baud_c >> 1) - 16'd1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!rx_s_q) begin
                    cnt_d   = per_q - 16'd1;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    sh_d  = {rx_s_q, sh_q[7:1]};
                    cnt_d = per_q - 16'd1;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (!cnt_zero) cnt_d = cnt_q - 16'd1;
                else           state_d = rx_s_q ? S_IDLE : S_BRK;
            end
            S_BRK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        push     = 1'b0;
        set_ovf  = 1'b0;
        set_ferr = 1'b0;
        if (state_q == S_STOP && cnt_zero) begin
            push     = rx_s_q && accept;
            set_ovf  = rx_s_q && !accept;
            set_ferr = !rx_s_q;
        end
        o_busy  = (state_q != S_IDLE);
        o_ready = (level != '0);
        o_level = level;
        o_D     = mem_q[rd_q[AW-1:0]];
        o_ferr  = ferr_q;
        o_ovf   = ovf_q;
    end

    // FIFO storage and sticky flags; set beats clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q[AW-1:0]] <= sh_q;
                wr_q <= wr_q + LVLW'(1);
            end
            if (pop) rd_q <= rd_q + LVLW'(1);
            ferr_q <= (ferr_q && !i_clr_err) || set_ferr;
            ovf_q  <= (ovf_q && !i_clr_err) || set_ovf;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames driven cycle by cycle, outputs
// sampled 1 time unit after the rising edge.
module tb_uart_rx_fifo;
    logic        i_clk, i_rst, i_rx, i_read, i_clr_err;
    logic [15:0] i_baud;
    logic [7:0]  o_D;
    logic        o_ready, o_busy, o_ferr, o_ovf;
    logic [2:0]  o_level;

    int total = 0;
    int bad   = 0;
    int rd_at  = -1;
    int chg_at = -1;
    logic [15:0] chg_val = 16'd0;

    uart_rx_fifo #(.DEPTH(4), .LVLW(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx(i_rx), .i_baud(i_baud),
        .i_read(i_read), .i_clr_err(i_clr_err), .o_D(o_D), .o_ready(o_ready),
        .o_level(o_level), .o_busy(o_busy), .o_ferr(o_ferr), .o_ovf(o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Drive one frame bit-accurately for ncyc cycles; rd_at/chg_at fire i_read / i_baud change at that cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int p, input int ncyc);
        int bitn;
        for (int c = 0; c < ncyc; c++) begin
            bitn = c / p;
            if (bitn == 0)      i_rx = 1'b0;
            else if (bitn <= 8) i_rx = b[bitn-1];
            else                i_rx = stop;
            i_read = (c == rd_at);
            if (c == chg_at) i_baud = chg_val;
            wait_cyc(1);
        end
        i_read = 1'b0;
        if (ncyc >= 10 * p) i_rx = 1'b1;
    endtask

    task automatic pop1;
        i_read = 1'b1;
        wait_cyc(1);
        i_read = 1'b0;
    endtask

    task automatic clr_flags;
        i_clr_err = 1'b1;
        wait_cyc(1);
        i_clr_err = 1'b0;
    endtask

    logic [7:0] exp_q [$];

    initial begin
        i_rst = 1'b1; i_rx = 1'b1; i_baud = 16'd16; i_read = 1'b0; i_clr_err = 1'b0;
        @(posedge i_clk); #1;
        wait_cyc(3);
        i_rst = 1'b0;
        chk("rst_ready", 32'(o_ready), 0);
        chk("rst_level", 32'(o_level), 0);
        chk("rst_busy",  32'(o_busy),  0);
        chk("rst_flags", 32'({o_ferr, o_ovf}), 0);
        chk("rst_D",     32'(o_D), 0);
        wait_cyc(2);

        // Single frame: push lands 155 cycles after start, inside the 164-cycle window
        send_frame(8'h55, 1'b1, 16, 160);
        chk("f55_ready", 32'(o_ready), 1);
        chk("f55_D",     32'(o_D), 32'h55);
        chk("f55_level", 32'(o_level), 1);
        chk("f55_flags", 32'({o_ferr, o_ovf}), 0);
        pop1();
        chk("f55_empty", 32'(o_ready), 0);
        pop1();
        chk("empty_rd_level", 32'(o_level), 0);

        // Back-to-back frames, then drain in order
        exp_q = '{8'h01, 8'h80, 8'hFF, 8'h00};
        foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, 16, 160);
        chk("b2b_level", 32'(o_level), 4);
        foreach (exp_q[i]) begin
            chk("b2b_D", 32'(o_D), 32'(exp_q[i]));
            pop1();
        end
        chk("b2b_level0", 32'(o_level), 0);
        chk("b2b_ready0", 32'(o_ready), 0);

        // Overflow: full FIFO drops the new byte
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, 16, 160);
        send_frame(8'hA5, 1'b1, 16, 160);
        chk("ovf_flag",  32'(o_ovf), 1);
        chk("ovf_level", 32'(o_level), 4);
        chk("ovf_head",  32'(o_D), 32'h11);
        clr_flags();
        chk("ovf_clr", 32'(o_ovf), 0);

        // Same again with a pop in the push cycle (cycle 2 + P/2 + 9P of the frame)
        rd_at = 154;
        send_frame(8'hA5, 1'b1, 16, 160);
        rd_at = -1;
        chk("pp_ovf",   32'(o_ovf), 0);
        chk("pp_level", 32'(o_level), 4);
        exp_q = '{8'h22, 8'h33, 8'h44, 8'hA5};
        foreach (exp_q[i]) begin
            chk("pp_D", 32'(o_D), 32'(exp_q[i]));
            pop1();
        end
        chk("pp_level0", 32'(o_level), 0);

        // Framing error on a low stop bit
        send_frame(8'h3C, 1'b0, 16, 160);
        wait_cyc(5);
        chk("ferr_flag",  32'(o_ferr), 1);
        chk("ferr_level", 32'(o_level), 0);
        chk("ferr_busy",  32'(o_busy), 0);
        clr_flags();

        // Held-low line: one ferr, then parked until the line goes high
        i_rx = 1'b0;
        wait_cyc(300);
        chk("brk_ferr", 32'(o_ferr), 1);
        clr_flags();
        wait_cyc(300);
        chk("brk_noferr", 32'(o_ferr), 0);
        chk("brk_busy",   32'(o_busy), 1);
        i_rx = 1'b1;
        wait_cyc(5);
        chk("brk_idle",  32'(o_busy), 0);
        chk("brk_level", 32'(o_level), 0);

        // Short glitch is rejected at the start-bit midpoint
        i_rx = 1'b0;
        wait_cyc(2);
        i_rx = 1'b1;
        wait_cyc(20);
        chk("gl_busy",  32'(o_busy), 0);
        chk("gl_level", 32'(o_level), 0);
        chk("gl_flags", 32'({o_ferr, o_ovf}), 0);

        // Reset in the middle of data bit 4, with a byte already buffered
        send_frame(8'h5A, 1'b1, 16, 160);
        send_frame(8'h00, 1'b1, 16, 16 + 4*16 + 8);
        i_rx = 1'b1;
        i_rst = 1'b1;
        wait_cyc(1);
        i_rst = 1'b0;
        chk("mr_busy",  32'(o_busy), 0);
        chk("mr_level", 32'(o_level), 0);
        chk("mr_ready", 32'(o_ready), 0);
        chk("mr_D",     32'(o_D), 0);
        wait_cyc(4);
        send_frame(8'h7E, 1'b1, 16, 160);
        chk("mr_7E",    32'(o_D), 32'h7E);
        chk("mr_lvl1",  32'(o_level), 1);
        pop1();

        // Bit-period clamp: 2 behaves as 4
        i_baud = 16'd2;
        send_frame(8'hC3, 1'b1, 4, 40);
        wait_cyc(6);
        chk("clamp_D",     32'(o_D), 32'hC3);
        chk("clamp_level", 32'(o_level), 1);
        chk("clamp_ferr",  32'(o_ferr), 0);
        pop1();

        // Period change mid-frame has no effect on the frame in flight
        i_baud = 16'd16;
        wait_cyc(2);
        chg_at = 80; chg_val = 16'd32;
        send_frame(8'h96, 1'b1, 16, 160);
        chg_at = -1;
        wait_cyc(2);
        chk("chg_D",    32'(o_D), 32'h96);
        chk("chg_ferr", 32'(o_ferr), 0);
        chk("chg_lvl",  32'(o_level), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
